// File: rtl/rx_arb_pkg.sv
// Shared types and defaults for the rx_fifo write-port arbiter.
package rx_arb_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      WRITE = 1'b1
   } arb_state_t;

   localparam int RX_DATA_WIDTH = 8;

endpackage

// File: rtl/rx_fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester searching upward from rr_ptr.
module rr_pick #(
   parameter int N_REQ = 2,
   parameter int PTR_W = 1
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [PTR_W-1:0] winner,
   output logic             any
);

   logic [N_REQ-1:0] rot_s;
   logic [PTR_W-1:0] off_s;
   logic [PTR_W:0]   sum_s;

   // Rotate so bit k is requester (rr_ptr+k) mod N_REQ, take the lowest set bit, map back
   always_comb begin
      rot_s = N_REQ'({req_valid, req_valid} >> rr_ptr);
      off_s = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         off_s = rot_s[k] ? PTR_W'(k) : off_s;
      end
      sum_s  = {1'b0, rr_ptr} + {1'b0, off_s};
      winner = (sum_s >= (PTR_W + 1)'(N_REQ)) ? PTR_W'(sum_s - (PTR_W + 1)'(N_REQ))
                                               : PTR_W'(sum_s);
      any    = |req_valid;
   end

endmodule

// File: rtl/rx_fifo_wr_arbiter.sv
// Round-robin arbiter sharing the rx_fifo write port between N_REQ receive sources,
// with full-stall timeout flags and a wrapping accepted-byte counter.
module rx_fifo_wr_arbiter
   import rx_arb_pkg::*;
#(
   parameter int N_REQ      = 2,
   parameter int DATA_WIDTH = RX_DATA_WIDTH,
   parameter int TIMEOUT    = 64,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [N_REQ-1:0]            req_valid,
   input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
   output logic [N_REQ-1:0]            req_ack,
   input  logic                        fifo_full,
   output logic                        fifo_w_enable,
   output logic [DATA_WIDTH-1:0]       fifo_w_data,
   output logic [N_REQ-1:0]            timeout_err,
   input  logic                        err_clear,
   output logic [CNT_WIDTH-1:0]        byte_count
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int ST_W  = $clog2(TIMEOUT + 2);
   localparam logic [ST_W-1:0] STALL_MAX = ST_W'(TIMEOUT + 1);

   arb_state_t            state_r, state_nxt_s;
   logic [PTR_W-1:0]      rr_ptr_r, rr_nxt_s, winner_s;
   logic                  any_s, grant_s;
   logic [N_REQ-1:0]      ack_r, err_r, err_set_s;
   logic                  w_en_r;
   logic [DATA_WIDTH-1:0] w_data_r, sel_data_s;
   logic [CNT_WIDTH-1:0]  cnt_r;
   logic [ST_W-1:0]       stall_r     [N_REQ];
   logic [ST_W-1:0]       stall_nxt_s [N_REQ];

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_rr_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr_r),
      .winner    (winner_s),
      .any       (any_s)
   );

   // Next-state: full is only looked at in IDLE, so the previous write has already landed
   always_comb begin
      state_nxt_s = state_r;
      grant_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (any_s && !fifo_full) begin
               grant_s     = 1'b1;
               state_nxt_s = WRITE;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WRITE:   state_nxt_s = IDLE;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Winner's byte and the pointer one past it
   always_comb begin
      sel_data_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sel_data_s = (winner_s == PTR_W'(i)) ? req_data[i*DATA_WIDTH +: DATA_WIDTH] : sel_data_s;
      end
      rr_nxt_s = (winner_s == PTR_W'(N_REQ - 1)) ? '0 : winner_s + PTR_W'(1);
   end

   // Stall counters saturate at TIMEOUT+1; reaching that value raises the error flag
   always_comb begin
      err_set_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         stall_nxt_s[i] = stall_r[i];
         if (!req_valid[i] || ack_r[i]) begin
            stall_nxt_s[i] = '0;
         end else if (fifo_full && (stall_r[i] != STALL_MAX)) begin
            stall_nxt_s[i] = stall_r[i] + ST_W'(1);
         end else begin
            stall_nxt_s[i] = stall_r[i];
         end
         err_set_s[i] = (stall_nxt_s[i] == STALL_MAX);
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Write-port outputs, pointer and byte counter all move together on a grant
   always_ff @(posedge clk) begin
      if (rst) begin
         w_en_r   <= 1'b0;
         w_data_r <= '0;
         ack_r    <= '0;
         rr_ptr_r <= '0;
         cnt_r    <= '0;
      end else begin
         w_en_r   <= grant_s;
         w_data_r <= grant_s ? sel_data_s : '0;
         ack_r    <= grant_s ? (N_REQ'(1) << winner_s) : '0;
         if (grant_s) begin
            rr_ptr_r <= rr_nxt_s;
            cnt_r    <= cnt_r + CNT_WIDTH'(1);
         end else begin
            rr_ptr_r <= rr_ptr_r;
            cnt_r    <= cnt_r;
         end
      end
   end

   // Stall counters and sticky timeout flags; a fresh set beats err_clear
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) stall_r[i] <= '0;
         err_r <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) stall_r[i] <= stall_nxt_s[i];
         err_r <= err_set_s | (err_clear ? '0 : err_r);
      end
   end

   assign req_ack       = ack_r;
   assign fifo_w_enable = w_en_r;
   assign fifo_w_data   = w_data_r;
   assign timeout_err   = err_r;
   assign byte_count    = cnt_r;

endmodule

// File: tb/tb_rx_fifo_wr_arbiter.sv
// Self-checking bench for rx_fifo_wr_arbiter: a cycle table plus hand sequences,
// with every FIFO write checked against a queue of expected {data, ack}.
module tb_rx_fifo_wr_arbiter;

   localparam int TIMEOUT = 64;

   typedef struct {
      logic       rst;
      logic [1:0] valid;
      logic [7:0] d0;
      logic [7:0] d1;
      logic       full;
      logic       wen;
      logic [7:0] wdata;
      logic [1:0] ack;
      logic [15:0] cnt;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] ack;
   } exp_t;

   logic        tb_clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [7:0]  d0, d1;
   logic [15:0] req_data;
   logic [1:0]  req_ack;
   logic        fifo_full;
   logic        fifo_w_enable;
   logic [7:0]  fifo_w_data;
   logic [1:0]  timeout_err;
   logic        err_clear;
   logic [15:0] byte_count;

   logic        w_wen;
   logic [7:0]  w_wdata;
   logic [1:0]  w_ack;
   logic [1:0]  w_err;
   logic [3:0]  w_cnt;

   logic        full_drv, use_model, r_en, prev_wen;
   logic [3:0]  occ;

   exp_t exp_q[$];
   vec_t vecs[13];
   int   n_checks = 0;
   int   n_fail   = 0;

   assign req_data  = {d1, d0};
   assign fifo_full = use_model ? (occ == 4'd8) : full_drv;

   rx_fifo_wr_arbiter #(.N_REQ(2), .DATA_WIDTH(8), .TIMEOUT(TIMEOUT), .CNT_WIDTH(16)) dut (
      .clk           (tb_clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ack       (req_ack),
      .fifo_full     (fifo_full),
      .fifo_w_enable (fifo_w_enable),
      .fifo_w_data   (fifo_w_data),
      .timeout_err   (timeout_err),
      .err_clear     (err_clear),
      .byte_count    (byte_count)
   );

   // Narrow-counter copy so counter wraparound is reachable in few cycles
   rx_fifo_wr_arbiter #(.N_REQ(2), .DATA_WIDTH(8), .TIMEOUT(TIMEOUT), .CNT_WIDTH(4)) u_wrap (
      .clk           (tb_clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ack       (w_ack),
      .fifo_full     (fifo_full),
      .fifo_w_enable (w_wen),
      .fifo_w_data   (w_wdata),
      .timeout_err   (w_err),
      .err_clear     (err_clear),
      .byte_count    (w_cnt)
   );

   initial tb_clk = 1'b0;
   always #5 tb_clk = ~tb_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // 8-deep rx_fifo occupancy model; also catches any write into a full FIFO
   always @(posedge tb_clk) begin
      if (!use_model || rst) begin
         occ <= 4'd0;
      end else begin
         if (fifo_w_enable === 1'b1) check("fifo_overflow", {31'd0, occ == 4'd8}, 32'd0);
         occ <= occ + ((fifo_w_enable === 1'b1 && occ != 4'd8) ? 4'd1 : 4'd0)
                     - ((r_en && occ != 4'd0) ? 4'd1 : 4'd0);
      end
   end

   // Scoreboard: every write must match the next expected entry; no back-to-back writes
   initial prev_wen = 1'b0;
   always @(negedge tb_clk) begin
      if (fifo_w_enable === 1'b1) begin
         check("wen_b2b", {31'd0, prev_wen}, 32'd0);
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got data %0h ack %0h expected no write", fifo_w_data, req_ack);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_data", {24'd0, fifo_w_data}, {24'd0, e.data});
            check("wr_ack", {30'd0, req_ack}, {30'd0, e.ack});
         end
      end
      prev_wen = (fifo_w_enable === 1'b1);
   end

   task automatic push_exp(input logic [7:0] data, input logic [1:0] ack);
      exp_t e;
      e.data = data;
      e.ack  = ack;
      exp_q.push_back(e);
   endtask

   task automatic do_reset(input logic model);
      rst       = 1'b1;
      req_valid = 2'b00;
      err_clear = 1'b0;
      r_en      = 1'b0;
      full_drv  = 1'b0;
      use_model = model;
      repeat (2) @(posedge tb_clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic wait_wen(input string name);
      logic got;
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
         @(posedge tb_clk);
         #1;
         got = fifo_w_enable;
      end
      check(name, {31'd0, got}, 32'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int         wcount, acks;
      logic [1:0] ack_seen;
      logic       got;

      rst = 1'b1; req_valid = 2'b00; d0 = 8'h00; d1 = 8'h00;
      err_clear = 1'b0; full_drv = 1'b0; use_model = 1'b0; r_en = 1'b0;

      //          rst   valid  d0     d1     full  | wen   wdata  ack    cnt
      vecs[0]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 16'd0};
      vecs[1]  = '{1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 16'd0};
      vecs[2]  = '{1'b0, 2'b01, 8'hA5, 8'h00, 1'b0, 1'b1, 8'hA5, 2'b01, 16'd1};
      vecs[3]  = '{1'b0, 2'b00, 8'hA5, 8'h00, 1'b0, 1'b0, 8'h00, 2'b00, 16'd1};
      vecs[4]  = '{1'b0, 2'b10, 8'h00, 8'h3C, 1'b1, 1'b0, 8'h00, 2'b00, 16'd1};
      vecs[5]  = '{1'b0, 2'b10, 8'h00, 8'h3C, 1'b0, 1'b1, 8'h3C, 2'b10, 16'd2};
      vecs[6]  = '{1'b0, 2'b01, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 2'b00, 16'd2};
      vecs[7]  = '{1'b0, 2'b01, 8'h5A, 8'h3C, 1'b0, 1'b1, 8'h5A, 2'b01, 16'd3};
      vecs[8]  = '{1'b0, 2'b00, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h00, 2'b00, 16'd3};
      vecs[9]  = '{1'b0, 2'b11, 8'h11, 8'h22, 1'b0, 1'b1, 8'h22, 2'b10, 16'd4};
      vecs[10] = '{1'b0, 2'b01, 8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 2'b00, 16'd4};
      vecs[11] = '{1'b0, 2'b01, 8'h11, 8'h22, 1'b0, 1'b1, 8'h11, 2'b01, 16'd5};
      vecs[12] = '{1'b0, 2'b00, 8'h11, 8'h22, 1'b0, 1'b0, 8'h00, 2'b00, 16'd5};

      // Reset values, single grant, full blocking, pointer rotation
      for (int i = 0; i < 13; i++) begin
         rst = vecs[i].rst; req_valid = vecs[i].valid;
         d0 = vecs[i].d0; d1 = vecs[i].d1; full_drv = vecs[i].full;
         if (vecs[i].wen) push_exp(vecs[i].wdata, vecs[i].ack);
         @(posedge tb_clk);
         #1;
         check($sformatf("vec%0d_wen", i), {31'd0, fifo_w_enable}, {31'd0, vecs[i].wen});
         check($sformatf("vec%0d_wdata", i), {24'd0, fifo_w_data}, {24'd0, vecs[i].wdata});
         check($sformatf("vec%0d_ack", i), {30'd0, req_ack}, {30'd0, vecs[i].ack});
         check($sformatf("vec%0d_cnt", i), {16'd0, byte_count}, {16'd0, vecs[i].cnt});
         if (i < 2) check($sformatf("vec%0d_err", i), {30'd0, timeout_err}, 32'd0);
      end

      // Both requesters continuously valid: strict alternation, one write per two cycles
      do_reset(1'b0);
      d0 = 8'h11; d1 = 8'h22; req_valid = 2'b11;
      for (int i = 0; i < 4; i++) begin
         push_exp(8'h11, 2'b01);
         push_exp(8'h22, 2'b10);
      end
      wcount = 0;
      repeat (16) begin
         @(posedge tb_clk);
         #1;
         if (fifo_w_enable) wcount++;
      end
      req_valid = 2'b00;
      check("rr_write_count", wcount, 32'd8);
      check("rr_byte_count", {16'd0, byte_count}, 32'd8);

      // Fill the 8-deep FIFO, confirm the stall, then drain one slot
      do_reset(1'b1);
      d0 = 8'h00; req_valid = 2'b01;
      for (int i = 0; i < 8; i++) push_exp(8'(i), 2'b01);
      acks = 0;
      repeat (30) begin
         @(posedge tb_clk);
         #1;
         if (req_ack[0]) begin
            acks++;
            d0 = d0 + 8'd1;
         end
      end
      check("fill_acks", acks, 32'd8);
      check("fill_full", {31'd0, fifo_full}, 32'd1);
      check("fill_no_timeout", {30'd0, timeout_err}, 32'd0);
      push_exp(8'h08, 2'b01);
      r_en = 1'b1;
      @(posedge tb_clk);
      #1;
      r_en = 1'b0;
      wait_wen("drain_9th_write");
      req_valid = 2'b00;
      repeat (2) @(posedge tb_clk);
      #1;

      // Stall timeout on requester 1, set-wins-over-clear, then clear
      do_reset(1'b0);
      full_drv = 1'b1; d1 = 8'h77; req_valid = 2'b10; ack_seen = 2'b00;
      repeat (TIMEOUT) begin
         @(posedge tb_clk);
         #1;
         ack_seen = ack_seen | req_ack;
      end
      check("timeout_not_yet", {30'd0, timeout_err}, 32'd0);
      @(posedge tb_clk);
      #1;
      check("timeout_set", {30'd0, timeout_err}, 32'd2);
      err_clear = 1'b1;
      @(posedge tb_clk);
      #1;
      check("timeout_set_wins", {30'd0, timeout_err}, 32'd2);
      req_valid = 2'b00;
      @(posedge tb_clk);
      #1;
      err_clear = 1'b0;
      ack_seen = ack_seen | req_ack;
      check("timeout_cleared", {30'd0, timeout_err}, 32'd0);
      check("timeout_no_ack", {30'd0, ack_seen}, 32'd0);
      full_drv = 1'b0;

      // Reset during WRITE aborts and restores requester 0 priority
      do_reset(1'b0);
      d0 = 8'hA1; req_valid = 2'b01;
      push_exp(8'hA1, 2'b01);
      @(posedge tb_clk);
      #1;
      check("pre_rst_write", {31'd0, fifo_w_enable}, 32'd1);
      rst = 1'b1; req_valid = 2'b11; d0 = 8'hB0; d1 = 8'hB1;
      @(posedge tb_clk);
      #1;
      check("rst_mid_wen", {31'd0, fifo_w_enable}, 32'd0);
      check("rst_mid_cnt", {16'd0, byte_count}, 32'd0);
      check("rst_mid_ack", {30'd0, req_ack}, 32'd0);
      rst = 1'b0;
      push_exp(8'hB0, 2'b01);
      @(posedge tb_clk);
      #1;
      check("post_rst_ack", {30'd0, req_ack}, 32'd1);
      check("post_rst_cnt", {16'd0, byte_count}, 32'd1);
      req_valid = 2'b00;
      repeat (2) @(posedge tb_clk);
      #1;

      // Byte counter wraparound on the 4-bit instance
      do_reset(1'b0);
      d0 = 8'hC0; req_valid = 2'b01;
      for (int g = 1; g <= 15; g++) begin
         push_exp(8'hC0, 2'b01);
         wait_wen($sformatf("wrap_grant%0d", g));
      end
      check("wrap_at_max", {28'd0, w_cnt}, 32'hF);
      push_exp(8'hC0, 2'b01);
      wait_wen("wrap_grant16");
      check("wrap_to_zero", {28'd0, w_cnt}, 32'h0);
      check("wide_count_16", {16'd0, byte_count}, 32'd16);
      req_valid = 2'b00;
      repeat (3) @(posedge tb_clk);
      #1;

      got = (exp_q.size() == 0);
      check("scoreboard_drained", {31'd0, got}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
